shift_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer sharing the single combinational 32-bit barrel shifter between two requesters, such as the ALU execute path and the load/store alignment path. It grants one request at a time and registers the operands that drive the shifter. It then captures the shifter result one cycle later and returns it with a one-cycle acknowledge pulse. The shifter instance sits outside this block; this block owns all of its input ports.

---
 rtl/shift_arbiter_if.sv | 49 ++++
 rtl/shift_arbiter.sv | 138 +++++++++++++
 tb/tb_shift_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// -----------------------------------------------------------------------------
// shift_arbiter_if
// Bundles the requester-facing handshake signals and the shared-shifter port
// signals of shift_arbiter.
//
// Handshake semantics (both requesters): REQx acts as "valid". It is held
// high with INx/SHFTx/SELx/ARITHx stable until ACKx is seen. ACKx is a
// one-cycle "done" pulse, and RESULT is valid in that same cycle. There is no
// separate ready: a request simply waits in REQx until the arbiter grants it.
// A REQx still high when the arbiter returns to idle counts as a new request.
//
// Modports
//   master : requester side plus shifter output (drives REQ/IN/SHFT/SEL/ARITH,
//            SH_OUT; observes ACK/RESULT/BUSY/SH_*)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface shift_arbiter_if;
   logic        REQ0;
   logic        REQ1;
   logic [31:0] IN0;
   logic [31:0] IN1;
   logic [4:0]  SHFT0;
   logic [4:0]  SHFT1;
   logic [1:0]  SEL0;
   logic [1:0]  SEL1;
   logic        ARITH0;
   logic        ARITH1;
   logic        ACK0;
   logic        ACK1;
   logic [31:0] RESULT;
   logic        BUSY;
   logic [31:0] SH_IN;
   logic [4:0]  SH_SHFT;
   logic [1:0]  SH_SEL;
   logic        SH_ARITH;
   logic [31:0] SH_OUT;

   modport master (
      output REQ0, REQ1, IN0, IN1, SHFT0, SHFT1, SEL0, SEL1, ARITH0, ARITH1,
      output SH_OUT,
      input  ACK0, ACK1, RESULT, BUSY, SH_IN, SH_SHFT, SH_SEL, SH_ARITH
   );

   modport slave (
      input  REQ0, REQ1, IN0, IN1, SHFT0, SHFT1, SEL0, SEL1, ARITH0, ARITH1,
      input  SH_OUT,
      output ACK0, ACK1, RESULT, BUSY, SH_IN, SH_SHFT, SH_SEL, SH_ARITH
   );
endinterface

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Round-robin arbiter and sequencer that shares one external combinational
// 32-bit barrel shifter between two requesters. A granted request has its
// operands registered onto SH_*. The shifter output is captured one cycle
// later into RESULT, and the winner receives a one-cycle ACK.
//
// Ports
//   CLK      : clock, rising edge
//   N_RST    : asynchronous active-low reset
//   bus      : shift_arbiter_if.slave (requests, ACK/RESULT/BUSY, shifter port)
//   state_o  : FSM state (0 = IDLE, 1 = SHIFT, 2 = RESP), for observation
//   grant_o  : requester currently granted
//   last_o   : requester served most recently (round-robin pointer)
// -----------------------------------------------------------------------------
module shift_arbiter (
   input  logic            CLK,
   input  logic            N_RST,
   shift_arbiter_if.slave  bus,
   output logic [1:0]      state_o,
   output logic            grant_o,
   output logic            last_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e      state_q,    state_d;
   logic        grant_q,    grant_d;
   logic        last_q,     last_d;
   logic        ack0_q,     ack0_d;
   logic        ack1_q,     ack1_d;
   logic [31:0] result_q,   result_d;
   logic [31:0] sh_in_q,    sh_in_d;
   logic [4:0]  sh_shft_q,  sh_shft_d;
   logic [1:0]  sh_sel_q,   sh_sel_d;
   logic        sh_arith_q, sh_arith_d;

   logic        any_req;
   logic        winner;
   logic [31:0] win_in;
   logic [4:0]  win_shft;
   logic [1:0]  win_sel;
   logic        win_arith;

   // On a tie, the requester that was not served last wins. With a single
   // request pending, REQ1 alone selects requester 1.
   assign any_req   = bus.REQ0 | bus.REQ1;
   assign winner    = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;
   assign win_in    = winner ? bus.IN1    : bus.IN0;
   assign win_shft  = winner ? bus.SHFT1  : bus.SHFT0;
   assign win_sel   = winner ? bus.SEL1   : bus.SEL0;
   assign win_arith = winner ? bus.ARITH1 : bus.ARITH0;

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         result_q   <= 32'd0;
         sh_in_q    <= 32'd0;
         sh_shft_q  <= 5'd0;
         sh_sel_q   <= 2'd0;
         sh_arith_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         result_q   <= result_d;
         sh_in_q    <= sh_in_d;
         sh_shft_q  <= sh_shft_d;
         sh_sel_q   <= sh_sel_d;
         sh_arith_q <= sh_arith_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      result_d   = result_q;
      sh_in_d    = sh_in_q;
      sh_shft_d  = sh_shft_q;
      sh_sel_d   = sh_sel_q;
      sh_arith_d = sh_arith_q;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d    = winner;
               sh_in_d    = win_in;
               sh_shft_d  = win_shft;
               sh_sel_d   = win_sel;
               // The shifter must never see a left shift with ARITH set.
               sh_arith_d = (win_sel == 2'd0) ? 1'b0 : win_arith;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            result_d = bus.SH_OUT;
            ack0_d   = ~grant_q;
            ack1_d   = grant_q;
            last_d   = grant_q;
            state_d  = RESP;
         end
         RESP: begin
            // Requests are not sampled here; ACKs fall back to 0 by default.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.ACK0     = ack0_q;
   assign bus.ACK1     = ack1_q;
   assign bus.RESULT   = result_q;
   assign bus.BUSY     = (state_q != IDLE);
   assign bus.SH_IN    = sh_in_q;
   assign bus.SH_SHFT  = sh_shft_q;
   assign bus.SH_SEL   = sh_sel_q;
   assign bus.SH_ARITH = sh_arith_q;

   assign state_o = state_q;
   assign grant_o = grant_q;
   assign last_o  = last_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Bench for shift_arbiter. Models the external barrel shifter, drives
// directed and random requests, and checks every transaction against a
// spec-level reference. The reference covers arbitration, the 3-cycle
// sequence, and the shift arithmetic.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_o;
   logic       grant_o;
   logic       last_o;

   int n_checks = 0;
   int n_pass   = 0;
   int last_m   = 1;

   shift_arbiter_if bus ();

   shift_arbiter dut (
      .CLK     (clk),
      .N_RST   (rst_n),
      .bus     (bus),
      .state_o (state_o),
      .grant_o (grant_o),
      .last_o  (last_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference shift ----------------
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                             input logic [1:0] op, input logic ar);
      logic signed [31:0] sd;
      logic [31:0]        r;
      case (op)
         2'd0: r = d << s;
         2'd1: begin
            if (ar) begin
               sd = d;
               sd = sd >>> s;
               r  = sd;
            end else begin
               r = d >> s;
            end
         end
         2'd2:    r = {{24{d[7]}}, d[7:0]} << s;
         default: r = {{16{d[15]}}, d[15:0]} << s;
      endcase
      return r;
   endfunction

   // External shifter; an illegal left+ARITH combination yields garbage.
   assign bus.SH_OUT = (bus.SH_SEL == 2'd0 && bus.SH_ARITH) ? 32'hDEAD_BEEF
                     : ref_shift(bus.SH_IN, bus.SH_SHFT, bus.SH_SEL, bus.SH_ARITH);

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req0(input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] op, input logic ar);
      bus.REQ0 = 1'b1; bus.IN0 = d; bus.SHFT0 = s; bus.SEL0 = op; bus.ARITH0 = ar;
   endtask

   task automatic set_req1(input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] op, input logic ar);
      bus.REQ1 = 1'b1; bus.IN1 = d; bus.SHFT1 = s; bus.SEL1 = op; bus.ARITH1 = ar;
   endtask

   task automatic rand_req0();
      set_req0($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
   endtask

   task automatic rand_req1();
      set_req1($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      last_m = 1;
   endtask

   // Called at a falling edge while idle with at least one REQ high.
   // Returns at the falling edge of the following idle cycle.
   task automatic run_txn(input bit drop, input bit scramble, output int win);
      logic [31:0] e_in;
      logic [4:0]  e_sh;
      logic [1:0]  e_sel;
      logic        e_ar;
      logic [31:0] e_res;
      if (bus.REQ0 && bus.REQ1) win = (last_m == 0) ? 1 : 0;
      else if (bus.REQ1)        win = 1;
      else                      win = 0;
      if (win == 0) begin
         e_in = bus.IN0; e_sh = bus.SHFT0; e_sel = bus.SEL0; e_ar = bus.ARITH0;
      end else begin
         e_in = bus.IN1; e_sh = bus.SHFT1; e_sel = bus.SEL1; e_ar = bus.ARITH1;
      end
      e_res = ref_shift(e_in, e_sh, e_sel, e_ar);

      @(posedge clk); @(negedge clk);             // SHIFT
      check("busy_shift", 32'(bus.BUSY), 32'd1);
      check("state_shift", 32'(state_o), 32'd1);
      check("grant", 32'(grant_o), 32'(win));
      check("sh_in", bus.SH_IN, e_in);
      check("sh_shft", 32'(bus.SH_SHFT), 32'(e_sh));
      check("sh_sel", 32'(bus.SH_SEL), 32'(e_sel));
      check("sh_arith", 32'(bus.SH_ARITH), (e_sel == 2'd0) ? 32'd0 : 32'(e_ar));
      check("ack_in_shift", 32'({bus.ACK1, bus.ACK0}), 32'd0);
      if (scramble) begin
         if (win == 0) rand_req0();
         else          rand_req1();
      end

      @(posedge clk); @(negedge clk);             // RESP
      check("ack", 32'({bus.ACK1, bus.ACK0}), (win == 1) ? 32'd2 : 32'd1);
      check("result", bus.RESULT, e_res);
      check("busy_resp", 32'(bus.BUSY), 32'd1);
      last_m = win;
      if (drop) begin
         if (win == 0) bus.REQ0 = 1'b0;
         else          bus.REQ1 = 1'b0;
      end

      @(posedge clk); @(negedge clk);             // IDLE
      check("ack_cleared", 32'({bus.ACK1, bus.ACK0}), 32'd0);
      check("busy_idle", 32'(bus.BUSY), 32'd0);
      check("result_held", bus.RESULT, e_res);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int w;
      int exp_order[4];
      exp_order = '{0, 1, 0, 1};
      rst_n = 1'b1;
      bus.REQ0 = 1'b0; bus.IN0 = '0; bus.SHFT0 = '0; bus.SEL0 = '0; bus.ARITH0 = 1'b0;
      bus.REQ1 = 1'b0; bus.IN1 = '0; bus.SHFT1 = '0; bus.SEL1 = '0; bus.ARITH1 = 1'b0;

      // Reset asserted mid-cycle; outputs must clear at once.
      #12 rst_n = 1'b0;
      #1;
      check("rst_acks", 32'({bus.ACK1, bus.ACK0}), 32'd0);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_result", bus.RESULT, 32'd0);
      check("rst_sh_in", bus.SH_IN, 32'd0);
      check("rst_sh_ctl", 32'({bus.SH_SHFT, bus.SH_SEL, bus.SH_ARITH}), 32'd0);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_last", 32'(last_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, logical left shift.
      set_req0(32'h0000_00F0, 5'd4, 2'd0, 1'b0);
      run_txn(1, 0, w);
      check("single_result", bus.RESULT, 32'h0000_0F00);

      // Tie from fresh reset: 0,1,0,1, one grant every 3 cycles.
      do_reset();
      rand_req0();
      rand_req1();
      for (int i = 0; i < 4; i++) begin
         run_txn(0, 0, w);
         check("tie_order", 32'(w), 32'(exp_order[i]));
      end
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;

      // Arithmetic right shift.
      set_req1(32'h8000_0000, 5'd31, 2'd1, 1'b1);
      run_txn(1, 0, w);
      check("asr_result", bus.RESULT, 32'hFFFF_FFFF);

      // Left shift with ARITH set is sanitised.
      set_req0(32'h0000_0001, 5'd31, 2'd0, 1'b1);
      run_txn(1, 0, w);
      check("lsl_arith_result", bus.RESULT, 32'h8000_0000);

      // Operands changed during SHIFT must not matter.
      set_req0(32'h1234_5678, 5'd8, 2'd1, 1'b0);
      run_txn(1, 1, w);
      check("latched_result", bus.RESULT, 32'h0012_3456);
      bus.REQ0 = 1'b0;

      // Reset during SHIFT: aborted, REQ1 re-serviced first.
      set_req1(32'h0000_00FF, 5'd4, 2'd2, 1'b0);
      @(posedge clk); @(negedge clk);
      check("pre_abort_busy", 32'(bus.BUSY), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_state", 32'(state_o), 32'd0);
      @(posedge clk); @(negedge clk);
      check("abort_no_ack", 32'({bus.ACK1, bus.ACK0}), 32'd0);
      rst_n  = 1'b1;
      last_m = 1;
      run_txn(1, 0, w);
      check("after_abort_winner", 32'(w), 32'd1);
      check("sext8_result", bus.RESULT, 32'hFFFF_FFF0);

      // Reset during RESP clears a high ACK asynchronously.
      set_req0(32'h0000_0003, 5'd1, 2'd0, 1'b0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("resp_ack_high", 32'(bus.ACK0), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("resp_ack_cleared", 32'({bus.ACK1, bus.ACK0}), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      last_m = 1;
      run_txn(1, 0, w);
      check("reservice_result", bus.RESULT, 32'h0000_0006);

      // Random traffic against the reference.
      for (int k = 0; k < 60; k++) begin
         if (!bus.REQ0 && ($urandom_range(0, 1) == 1 || !bus.REQ1)) rand_req0();
         if (!bus.REQ1 && $urandom_range(0, 1) == 1) rand_req1();
         run_txn(1, 1'($urandom_range(0, 1)), w);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
